// File: rtl/exec_unit.sv
// exec_unit: RV32I/M execute stage between decode and memory/writeback.
//   Single-cycle ALU / immediate ALU, load/store address generation,
//   branch and jump resolution, optional iterative shift-add multiplier.
//   Results are held in a registered output slot under back-pressure.
//
// Ports
//   iClk, iRst                 clock (rising edge), async active-low reset
//   iValid / oReady            instruction handshake from decode
//   iOpcode, iFunct3, iFunct7  decoded instruction fields
//   iRs1Data, iRs2Data, iImm   operands and sign-extended immediate
//   iPc, iRdAddr               instruction PC and destination register
//   oValid / iReady            result handshake towards mem/writeback
//   oRegWe, oRegAddr, oRegData register writeback
//   oMemRd, oMemWr, oMemAddr,  memory request (address rs1+imm, store data,
//   oMemData, oMemOp           funct3 size/sign passthrough)
//   oBrTaken, oBrTarget        fetch redirect
//   oIllegal                   unsupported opcode/funct
//
// FSM states
//   state   | meaning
//   IDLE    | accepting; single-cycle ops complete here
//   MUL     | shift-add iterations; counter DATA_W-2..0 (first step runs on accept edge)
//   FIX     | sign fixup, wait for free slot, load result
module exec_unit #(
    parameter int DATA_W = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic [6:0]        iOpcode,
    input  logic [2:0]        iFunct3,
    input  logic [6:0]        iFunct7,
    input  logic [DATA_W-1:0] iRs1Data,
    input  logic [DATA_W-1:0] iRs2Data,
    input  logic [DATA_W-1:0] iImm,
    input  logic [DATA_W-1:0] iPc,
    input  logic [4:0]        iRdAddr,
    output logic              oValid,
    input  logic              iReady,
    output logic              oRegWe,
    output logic [4:0]        oRegAddr,
    output logic [DATA_W-1:0] oRegData,
    output logic              oMemRd,
    output logic              oMemWr,
    output logic [DATA_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemData,
    output logic [2:0]        oMemOp,
    output logic              oBrTaken,
    output logic [DATA_W-1:0] oBrTarget,
    output logic              oIllegal
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_FIX} state_t;

    typedef struct packed {
        logic              reg_we;
        logic [4:0]        reg_addr;
        logic [DATA_W-1:0] reg_data;
        logic              mem_rd;
        logic              mem_wr;
        logic [DATA_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_data;
        logic [2:0]        mem_op;
        logic              br_taken;
        logic [DATA_W-1:0] br_target;
        logic              illegal;
    } slot_t;

    state_t              state, state_nxt;
    slot_t               slot, dec, fix_res;
    logic                slot_valid;
    logic                is_mul, accept, load_dec, load_fix, start_mul;
    logic                br_eq, br_lt, br_ltu;
    logic                sgn_a, sgn_b;
    logic [DATA_W-1:0]   mag_a, mag_b, agu;
    logic [DATA_W-1:0]   mul_a;
    logic [2*DATA_W-1:0] mul_p, prod_fix;
    logic                mul_neg, mul_hi;
    logic [4:0]          mul_rd;
    logic [SH_W-1:0]     mul_cnt;

    function automatic logic [DATA_W-1:0] alu(input logic [2:0] f3, input logic alt,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [SH_W-1:0]          sh;
        logic signed [DATA_W-1:0] sa;
        logic [DATA_W-1:0]        sra;
        sh  = b[SH_W-1:0];
        sa  = a;
        // kept in its own statement so the shift stays signed
        sra = sa >>> sh;
        case (f3)
            3'b000:  alu = alt ? a - b : a + b;
            3'b001:  alu = a << sh;
            3'b010:  alu = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011:  alu = {{(DATA_W-1){1'b0}}, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = alt ? sra : a >> sh;
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    // One shift-add step on {acc_hi, multiplier_lo}; the carry lands in the top bit.
    function automatic logic [2*DATA_W-1:0] mul_step(input logic [2*DATA_W-1:0] p,
                                                     input logic [DATA_W-1:0] a);
        logic [DATA_W:0] upper;
        upper    = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, a} : '0);
        mul_step = {upper, p[DATA_W-1:1]};
    endfunction

    assign agu    = iRs1Data + iImm;
    assign br_eq  = iRs1Data == iRs2Data;
    assign br_lt  = $signed(iRs1Data) < $signed(iRs2Data);
    assign br_ltu = iRs1Data < iRs2Data;

    always_comb begin
        dec    = '0;
        is_mul = 1'b0;
        case (iOpcode)
            OP_R: begin
                if (iFunct7 == 7'b0000001) begin
                    if (MUL_EN && !iFunct3[2]) is_mul = 1'b1;
                    else                       dec.illegal = 1'b1;
                end else if (iFunct7 == 7'b0000000 ||
                             (iFunct7 == 7'b0100000 && (iFunct3 == 3'b000 || iFunct3 == 3'b101))) begin
                    dec.reg_we   = 1'b1;
                    dec.reg_addr = iRdAddr;
                    dec.reg_data = alu(iFunct3, iFunct7[5], iRs1Data, iRs2Data);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_I: begin
                dec.reg_we   = 1'b1;
                dec.reg_addr = iRdAddr;
                dec.reg_data = alu(iFunct3, (iFunct3 == 3'b101) && iFunct7[5], iRs1Data, iImm);
            end
            OP_LOAD: begin
                dec.mem_rd   = 1'b1;
                dec.mem_addr = agu;
                dec.mem_op   = iFunct3;
                dec.reg_addr = iRdAddr;
            end
            OP_STORE: begin
                dec.mem_wr   = 1'b1;
                dec.mem_addr = agu;
                dec.mem_data = iRs2Data;
                dec.mem_op   = iFunct3;
            end
            OP_BRANCH: begin
                dec.br_target = iPc + iImm;
                case (iFunct3)
                    3'b000:  dec.br_taken = br_eq;
                    3'b001:  dec.br_taken = !br_eq;
                    3'b100:  dec.br_taken = br_lt;
                    3'b101:  dec.br_taken = !br_lt;
                    3'b110:  dec.br_taken = br_ltu;
                    3'b111:  dec.br_taken = !br_ltu;
                    default: dec.illegal  = 1'b1;
                endcase
            end
            OP_JAL, OP_JALR: begin
                dec.reg_we    = 1'b1;
                dec.reg_addr  = iRdAddr;
                dec.reg_data  = iPc + DATA_W'(4);
                dec.br_taken  = 1'b1;
                dec.br_target = (iOpcode == OP_JAL) ? iPc + iImm : {agu[DATA_W-1:1], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_we   = 1'b1;
                dec.reg_addr = iRdAddr;
                dec.reg_data = (iOpcode == OP_LUI) ? iImm : iPc + iImm;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // MULH: both operands signed; MULHSU: rs1 only; MUL/MULHU: unsigned.
    assign sgn_a    = iRs1Data[DATA_W-1] && (iFunct3[1:0] == 2'b01 || iFunct3[1:0] == 2'b10);
    assign sgn_b    = iRs2Data[DATA_W-1] && (iFunct3[1:0] == 2'b01);
    assign mag_a    = sgn_a ? -iRs1Data : iRs1Data;
    assign mag_b    = sgn_b ? -iRs2Data : iRs2Data;
    assign prod_fix = mul_neg ? -mul_p : mul_p;

    always_comb begin
        fix_res          = '0;
        fix_res.reg_we   = 1'b1;
        fix_res.reg_addr = mul_rd;
        fix_res.reg_data = mul_hi ? prod_fix[2*DATA_W-1:DATA_W] : prod_fix[DATA_W-1:0];
    end

    assign oReady = (state == ST_IDLE) && (!slot_valid || iReady);
    assign accept = iValid && oReady;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_dec  = 1'b0;
        start_mul = 1'b0;
        load_fix  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        start_mul = 1'b1;
                        state_nxt = ST_MUL;
                    end else begin
                        load_dec = 1'b1;
                    end
                end
            end
            ST_MUL: if (mul_cnt == '0) state_nxt = ST_FIX;
            // a previous result may still be stalled in the slot
            ST_FIX: begin
                if (!slot_valid || iReady) begin
                    load_fix  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            mul_p   <= '0;
            mul_a   <= '0;
            mul_neg <= 1'b0;
            mul_hi  <= 1'b0;
            mul_rd  <= '0;
            mul_cnt <= '0;
        end else if (start_mul) begin
            // first partial product is taken on the accept edge
            mul_p   <= mul_step({{DATA_W{1'b0}}, mag_b}, mag_a);
            mul_a   <= mag_a;
            mul_neg <= sgn_a ^ sgn_b;
            mul_hi  <= iFunct3[1:0] != 2'b00;
            mul_rd  <= iRdAddr;
            mul_cnt <= SH_W'(DATA_W - 2);
        end else if (state == ST_MUL) begin
            mul_p   <= mul_step(mul_p, mul_a);
            mul_cnt <= mul_cnt - 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            slot       <= '0;
            slot_valid <= 1'b0;
        end else if (load_dec) begin
            slot       <= dec;
            slot_valid <= 1'b1;
        end else if (load_fix) begin
            slot       <= fix_res;
            slot_valid <= 1'b1;
        end else if (slot_valid && iReady) begin
            slot       <= '0;
            slot_valid <= 1'b0;
        end
    end

    assign oValid    = slot_valid;
    assign oRegWe    = slot.reg_we;
    assign oRegAddr  = slot.reg_addr;
    assign oRegData  = slot.reg_data;
    assign oMemRd    = slot.mem_rd;
    assign oMemWr    = slot.mem_wr;
    assign oMemAddr  = slot.mem_addr;
    assign oMemData  = slot.mem_data;
    assign oMemOp    = slot.mem_op;
    assign oBrTaken  = slot.br_taken;
    assign oBrTarget = slot.br_target;
    assign oIllegal  = slot.illegal;

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: directed corner cases plus randomized
// instructions, scored against a reference model through an expected queue.
module tb_exec_unit;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mrd;
        logic        mwr;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [2:0]  mop;
        logic        br;
        logic [31:0] tgt;
        logic        ill;
    } res_t;

    logic        iClk = 1'b0, iRst = 1'b0, iValid = 1'b0;
    logic [6:0]  iOpcode = '0, iFunct7 = '0;
    logic [2:0]  iFunct3 = '0;
    logic [31:0] iRs1Data = '0, iRs2Data = '0, iImm = '0, iPc = '0;
    logic [4:0]  iRdAddr = '0;
    logic        iReady, oReady, oValid, oRegWe, oMemRd, oMemWr, oBrTaken, oIllegal;
    logic [4:0]  oRegAddr;
    logic [31:0] oRegData, oMemAddr, oMemData, oBrTarget;
    logic [2:0]  oMemOp;

    logic rr = 1'b1, dir_rdy = 1'b1, rand_rdy = 1'b0;
    assign iReady = rand_rdy ? rr : dir_rdy;

    always #5 iClk = ~iClk;

    exec_unit #(.DATA_W(32), .MUL_EN(1'b1)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iOpcode(iOpcode), .iFunct3(iFunct3), .iFunct7(iFunct7),
        .iRs1Data(iRs1Data), .iRs2Data(iRs2Data), .iImm(iImm), .iPc(iPc),
        .iRdAddr(iRdAddr), .oValid(oValid), .iReady(iReady),
        .oRegWe(oRegWe), .oRegAddr(oRegAddr), .oRegData(oRegData),
        .oMemRd(oMemRd), .oMemWr(oMemWr), .oMemAddr(oMemAddr),
        .oMemData(oMemData), .oMemOp(oMemOp), .oBrTaken(oBrTaken),
        .oBrTarget(oBrTarget), .oIllegal(oIllegal)
    );

    res_t exp_q[$];
    int   n_cmp = 0, n_err = 0, beats = 0, n_push = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic res_t actual();
        res_t r;
        r = '{oRegWe, oRegAddr, oRegData, oMemRd, oMemWr, oMemAddr, oMemData,
              oMemOp, oBrTaken, oBrTarget, oIllegal};
        return r;
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (alt) r = sa >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic res_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                   input logic [31:0] pc, input logic [4:0] rd);
        res_t        r;
        longint      sa, sb;
        logic [63:0] p;
        logic        t;
        r = '0;
        t = 1'b0;
        case (op)
            OP_R: begin
                if (f7 == 7'h01 && !f3[2]) begin
                    sa = longint'(a);
                    sb = longint'(b);
                    if (f3 == 3'd1 || f3 == 3'd2) sa = longint'($signed(a));
                    if (f3 == 3'd1)               sb = longint'($signed(b));
                    p = sa * sb;
                    r.we = 1'b1; r.addr = rd;
                    r.data = (f3 == 3'd0) ? p[31:0] : p[63:32];
                end else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    r.we = 1'b1; r.addr = rd; r.data = m_alu(f3, f7 == 7'h20, a, b);
                end else begin
                    r.ill = 1'b1;
                end
            end
            OP_I: begin
                r.we = 1'b1; r.addr = rd; r.data = m_alu(f3, f3 == 3'd5 && f7[5], a, imm);
            end
            OP_LOAD:  begin r.mrd = 1'b1; r.maddr = a + imm; r.mop = f3; r.addr = rd; end
            OP_STORE: begin r.mwr = 1'b1; r.maddr = a + imm; r.mdata = b; r.mop = f3; end
            OP_BRANCH: begin
                r.tgt = pc + imm;
                case (f3)
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = ($signed(a) < $signed(b));
                    3'd5: t = ($signed(a) >= $signed(b));
                    3'd6: t = (a < b);
                    3'd7: t = (a >= b);
                    default: r.ill = 1'b1;
                endcase
                r.br = t;
            end
            OP_JAL:   begin r.we = 1'b1; r.addr = rd; r.data = pc + 4; r.br = 1'b1; r.tgt = pc + imm; end
            OP_JALR:  begin r.we = 1'b1; r.addr = rd; r.data = pc + 4; r.br = 1'b1; r.tgt = (a + imm) & ~32'd1; end
            OP_LUI:   begin r.we = 1'b1; r.addr = rd; r.data = imm; end
            OP_AUIPC: begin r.we = 1'b1; r.addr = rd; r.data = pc + imm; end
            default:  r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Drive one instruction, hold it until accepted, push its expected result.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] rd, input bit push,
                         output int waits);
        iOpcode = op; iFunct3 = f3; iFunct7 = f7; iRs1Data = a; iRs2Data = b;
        iImm = imm; iPc = pc; iRdAddr = rd; iValid = 1'b1;
        waits = 0;
        @(negedge iClk);
        while (!oReady && waits < 200) begin
            waits++;
            @(negedge iClk);
        end
        check("accept", oReady, 1'b1);
        if (oReady && push) begin
            exp_q.push_back(model(op, f3, f7, a, b, imm, pc, rd));
            n_push++;
        end
        @(posedge iClk);
        #1;
        iValid = 1'b0;
    endtask

    task automatic mul_directed(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] want, input string name);
        int w, bad;
        issue(OP_R, f3, 7'h01, a, b, 32'd0, 32'd0, 5'd9, 1'b1, w);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge iClk);
            if (oValid || oReady) bad++;
        end
        @(negedge iClk);
        check({name, "_busy"}, bad, 0);
        check({name, "_latency"}, oValid, 1'b1);
        check(name, oRegData, want);
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops and compares on every result beat, checks hold stability.
    initial begin
        res_t prev;
        bit   hold;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge iClk);
            if (!iRst) begin
                hold = 1'b0;
            end else begin
                if (hold && oValid) check("hold_stable", actual(), prev);
                if (oValid && iReady) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %h want no beat", actual());
                    end else begin
                        check("result", actual(), exp_q.pop_front());
                    end
                    hold = 1'b0;
                end else if (oValid) begin
                    hold = 1'b1;
                    prev = actual();
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge iClk);
            #1;
            rr = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, bad, b0, t, k;
        logic [6:0]  op, f7;
        logic [2:0]  f3;

        repeat (3) @(posedge iClk);
        #1;
        check("reset_outputs", actual(), '0);
        check("reset_valid", oValid, 1'b0);
        check("reset_ready", oReady, 1'b1);
        iRst = 1'b1;
        @(posedge iClk);
        #1;

        issue(OP_R, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'h1, 32'd0, 32'd0, 5'd3, 1'b1, w);
        @(negedge iClk);
        check("add_latency", oValid, 1'b1);
        check("add_overflow", oRegData, 32'h8000_0000);
        @(posedge iClk); #1;

        issue(OP_R, 3'd5, 7'h20, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 5'd4, 1'b1, w);
        @(negedge iClk);
        check("sra", oRegData, 32'hF800_0000);
        @(posedge iClk); #1;
        issue(OP_R, 3'd5, 7'h00, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 5'd4, 1'b1, w);
        @(negedge iClk);
        check("srl", oRegData, 32'h0800_0000);
        @(posedge iClk); #1;

        issue(OP_BRANCH, 3'd0, 7'h00, 32'd5, 32'd5, 32'hFFFF_FFF8, 32'h100, 5'd0, 1'b1, w);
        @(negedge iClk);
        check("beq_taken", oBrTaken, 1'b1);
        check("beq_target", oBrTarget, 32'hF8);
        @(posedge iClk); #1;
        issue(OP_BRANCH, 3'd6, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd16, 32'h200, 5'd0, 1'b1, w);
        @(negedge iClk);
        check("bltu_not_taken", oBrTaken, 1'b0);
        @(posedge iClk); #1;

        mul_directed(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        mul_directed(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, "mulh");
        mul_directed(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, "mul");

        // back-pressure: result 0x1234 held three cycles, then released
        dir_rdy = 1'b0;
        issue(OP_I, 3'd0, 7'h00, 32'h1000, 32'd0, 32'h234, 32'd0, 5'd7, 1'b1, w);
        bad = 0;
        repeat (3) begin
            @(negedge iClk);
            if (!oValid || oRegData !== 32'h1234 || oReady) bad++;
        end
        check("bp_hold", bad, 0);
        b0 = beats;
        @(posedge iClk); #1;
        dir_rdy = 1'b1;
        issue(OP_R, 3'd4, 7'h00, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'd0, 5'd8, 1'b1, w);
        check("bp_one_beat", beats, b0 + 1);
        check("bp_accept_same_cycle", w, 0);
        @(negedge iClk);
        check("bp_next_valid", oValid, 1'b1);
        @(posedge iClk); #1;
        check("bp_next_beat", beats, b0 + 2);

        // reset in the middle of a multiply
        issue(OP_R, 3'd0, 7'h01, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 5'd5, 1'b0, w);
        repeat (9) @(posedge iClk);
        #3;
        iRst = 1'b0;
        #1;
        check("rst_outputs", actual(), '0);
        check("rst_valid", oValid, 1'b0);
        check("rst_ready", oReady, 1'b1);
        @(posedge iClk); #1;
        iRst = 1'b1;
        b0 = beats;
        repeat (40) @(posedge iClk);
        #1;
        check("rst_no_beat", beats, b0);

        // randomized phase with random downstream stalls
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            k  = $urandom_range(0, 11);
            f3 = 3'($urandom_range(0, 7));
            f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            case (k)
                0, 1:  op = OP_R;
                2, 3:  begin op = OP_R; f7 = 7'h01; end
                4, 5:  op = OP_I;
                6:     op = OP_LOAD;
                7:     op = OP_STORE;
                8:     op = OP_BRANCH;
                9:     op = ($urandom_range(0, 1) != 0) ? OP_JAL : OP_JALR;
                10:    op = ($urandom_range(0, 1) != 0) ? OP_LUI : OP_AUIPC;
                default: begin
                    if ($urandom_range(0, 1) != 0) begin
                        op = OP_R; f7 = 7'($urandom);
                    end else begin
                        op = ($urandom_range(0, 1) != 0) ? 7'b1110011 : 7'b0001111;
                    end
                end
            endcase
            issue(op, f3, f7, rnd32(), rnd32(), rnd32(), $urandom, 5'($urandom), 1'b1, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge iClk); #1;
            end
        end

        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge iClk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        rand_rdy = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        check("beat_count", beats, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
